// File: rtl/sys_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sys_cfg_pkg
//   Shared types and constants for the double-buffered system-config bank.
//   - pi_bus_t    : PI bus bundle as seen by the cfg bank (act, we, addr, dato,
//                   map.ce_cfg)
//   - CFG_CTRL_*  : offsets within the control page
//   - CTRL_BIT_*  : command bits of control register 0
//   - STAT_BIT_*  : bit positions inside the STATUS byte
//   - cmt_state_t : commit FSM states
// ---------------------------------------------------------------------------
package sys_cfg_pkg;

  // Wide enough for the largest bank (256 regs + ctrl page select bit).
  localparam int PI_AW = 9;
  localparam int PI_DW = 8;

  typedef struct packed {
    logic ce_cfg;
  } pi_map_t;

  typedef struct packed {
    logic             act;
    logic             we;
    logic [PI_AW-1:0] addr;
    logic [PI_DW-1:0] dato;
    pi_map_t          map;
  } pi_bus_t;

  // Control page offsets (addr[1:0] when addr[AW] = 1)
  localparam logic [1:0] CFG_CTRL_CMD    = 2'd0;
  localparam logic [1:0] CFG_CTRL_STATUS = 2'd1;
  localparam logic [1:0] CFG_CTRL_CSUM   = 2'd2;
  localparam logic [1:0] CFG_CTRL_INFO   = 2'd3;

  // Command register bits
  localparam int CTRL_BIT_COMMIT  = 0;
  localparam int CTRL_BIT_DISCARD = 1;
  localparam int CTRL_BIT_FORCE   = 2;

  // STATUS register bits
  localparam int STAT_BIT_DIRTY = 0;
  localparam int STAT_BIT_PEND  = 1;
  localparam int STAT_BIT_BUSY  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    COPY = 2'd2
  } cmt_state_t;

  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic pend,
                                             input logic dirty);
    logic [7:0] s;
    s                 = '0;
    s[STAT_BIT_DIRTY] = dirty;
    s[STAT_BIT_PEND]  = pend;
    s[STAT_BIT_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/cfg_csum_walk.sv
// ---------------------------------------------------------------------------
// cfg_csum_walk
//   Walks the active register file one entry per cycle after a commit and
//   produces the modulo-2^DW sum of all entries.
//   Ports:
//     clk, rst   : clock, async active-high reset
//     i_start    : pulse; (re)starts the walk from reg 0
//     i_data     : active register value selected by o_idx
//     o_idx      : index of the register currently being summed
//     o_busy     : high while the walk is in progress (REG_NUM cycles)
//     o_csum     : last completed checksum
// ---------------------------------------------------------------------------
module cfg_csum_walk #(
  parameter int REG_NUM = 16,
  parameter int DW      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [DW-1:0]              i_data,
  output logic [$clog2(REG_NUM)-1:0] o_idx,
  output logic                       o_busy,
  output logic [DW-1:0]              o_csum
);

  localparam int AW = $clog2(REG_NUM);

  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_acc;
  logic          r_busy;
  logic [DW-1:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_acc  <= '0;
      r_busy <= 1'b0;
      r_csum <= '0;
    end else if (i_start) begin
      // A fresh commit invalidates any walk in progress.
      r_idx  <= '0;
      r_acc  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= r_acc + i_data;
      r_idx <= r_idx + 1'b1;
      if (r_idx == AW'(REG_NUM - 1)) begin
        r_busy <= 1'b0;
        r_csum <= r_acc + i_data;
      end
    end
  end

  assign o_idx  = r_idx;
  assign o_busy = r_busy;
  assign o_csum = r_csum;

endmodule

// File: rtl/sys_cfg_bank.sv
// ---------------------------------------------------------------------------
// sys_cfg_bank
//   Double-buffered system-config register bank. PI writes land in shadow
//   registers; a commit copies every shadow register into the active set in
//   one cycle so the mapper logic never sees a half-updated configuration.
//   Optional feature macro: CFG_CSUM_EN (post-commit checksum walker).
//   Ports:
//     clk, rst     : clock, async active-high reset
//     i_pi         : PI bus (act, we, addr, dato, map.ce_cfg)
//     i_safe_pt    : strobe from the mapper side, safe to swap config
//     o_pi_di      : registered readback data (1-cycle latency)
//     o_cfg_act    : active registers, reg i at [i*DW +: DW]
//     o_cfg_upd    : 1-cycle pulse on the cycle the active registers change
//     o_cmt_pend   : commit requested and not yet finished
// ---------------------------------------------------------------------------
module sys_cfg_bank
  import sys_cfg_pkg::*;
#(
  parameter int REG_NUM = 16,
  parameter int DW      = 8,
  parameter int TMO_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pi_bus_t               i_pi,
  input  logic                  i_safe_pt,
  output logic [DW-1:0]         o_pi_di,
  output logic [REG_NUM*DW-1:0] o_cfg_act,
  output logic                  o_cfg_upd,
  output logic                  o_cmt_pend
);

  localparam int AW = $clog2(REG_NUM);
  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  // Write capture stage
  logic          r_we_st;
  logic [AW:0]   r_addr_st;
  logic [DW-1:0] r_dat_st;

  logic [DW-1:0] r_shadow [REG_NUM];
  logic [DW-1:0] r_active [REG_NUM];

  cmt_state_t    r_state;
  logic [CW-1:0] r_tmo_cnt;
  logic          r_dirty;
  logic          r_cfg_upd;
  logic [DW-1:0] r_pi_di;

  logic          w_sh_wr;
  logic          w_ctrl_cmd;
  logic          w_commit;
  logic          w_discard;
  logic          w_force;
  logic          w_tmo;
  logic          w_csum_busy;
  logic [DW-1:0] w_csum;
  logic [DW-1:0] w_rd_data;
  logic          w_unused_pi;

  // Only addr[AW:0] is decoded; the rest of the bundle is consumed here.
  assign w_unused_pi = ^i_pi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_st   <= 1'b0;
      r_addr_st <= '0;
      r_dat_st  <= '0;
    end else begin
      r_we_st   <= i_pi.act & i_pi.we & i_pi.map.ce_cfg;
      r_addr_st <= i_pi.addr[AW:0];
      r_dat_st  <= DW'(i_pi.dato);
    end
  end

  assign w_sh_wr    = r_we_st & ~r_addr_st[AW];
  assign w_ctrl_cmd = r_we_st & r_addr_st[AW] & (r_addr_st[1:0] == CFG_CTRL_CMD);
  assign w_commit   = w_ctrl_cmd & r_dat_st[CTRL_BIT_COMMIT];
  assign w_discard  = w_ctrl_cmd & r_dat_st[CTRL_BIT_DISCARD];
  assign w_force    = w_ctrl_cmd & r_dat_st[CTRL_BIT_FORCE];

  generate
    if (TMO_CYC > 0) begin : g_tmo
      assign w_tmo = (r_tmo_cnt == CW'(TMO_CYC - 1));
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end
  endgenerate

  // Commit FSM plus shadow/active storage. The copy into active happens on
  // the edge that enters COPY, so the COPY cycle is the one where the new
  // values are visible and cfg_upd is high. A shadow write acting in that
  // same cycle lands afterwards and re-marks the bank dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmo_cnt <= '0;
      r_dirty   <= 1'b0;
      r_cfg_upd <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_cfg_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_discard) begin
            for (int i = 0; i < REG_NUM; i++) r_shadow[i] <= r_active[i];
            r_dirty <= 1'b0;
          end else if (w_force) begin
            for (int i = 0; i < REG_NUM; i++) r_active[i] <= r_shadow[i];
            r_dirty   <= 1'b0;
            r_cfg_upd <= 1'b1;
            r_state   <= COPY;
          end else if (w_commit) begin
            // safe_pt in this cycle is deliberately not honoured yet.
            r_tmo_cnt <= '0;
            r_state   <= PEND;
          end
        end
        PEND: begin
          if (w_discard) begin
            for (int i = 0; i < REG_NUM; i++) r_shadow[i] <= r_active[i];
            r_dirty <= 1'b0;
            r_state <= IDLE;
          end else if (i_safe_pt | w_force | w_tmo) begin
            for (int i = 0; i < REG_NUM; i++) r_active[i] <= r_shadow[i];
            r_dirty   <= 1'b0;
            r_cfg_upd <= 1'b1;
            r_state   <= COPY;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        COPY: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Placed last so a write coinciding with a copy still leaves dirty set.
      if (w_sh_wr) begin
        r_shadow[r_addr_st[AW-1:0]] <= r_dat_st;
        r_dirty                     <= 1'b1;
      end
    end
  end

`ifdef CFG_CSUM_EN
  logic [AW-1:0] w_walk_idx;

  cfg_csum_walk #(
    .REG_NUM (REG_NUM),
    .DW      (DW)
  ) u_csum_walk (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_cfg_upd),
    .i_data  (r_active[w_walk_idx]),
    .o_idx   (w_walk_idx),
    .o_busy  (w_csum_busy),
    .o_csum  (w_csum)
  );
`else
  assign w_csum_busy = 1'b0;
  assign w_csum      = '0;
`endif

  // Readback decode on the live PI address; shadow page returns shadow.
  always_comb begin
    w_rd_data = '0;
    if (!i_pi.addr[AW]) begin
      w_rd_data = r_shadow[i_pi.addr[AW-1:0]];
    end else begin
      case (i_pi.addr[1:0])
        CFG_CTRL_STATUS: w_rd_data = DW'(status_byte(w_csum_busy, r_state != IDLE, r_dirty));
        CFG_CTRL_CSUM:   w_rd_data = w_csum;
        CFG_CTRL_INFO:   w_rd_data = DW'(REG_NUM - 1);
        default:         w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pi_di <= '0;
    end else begin
      r_pi_di <= w_rd_data;
    end
  end

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_act
      assign o_cfg_act[gi*DW +: DW] = r_active[gi];
    end
  endgenerate

  assign o_pi_di    = r_pi_di;
  assign o_cfg_upd  = r_cfg_upd;
  assign o_cmt_pend = (r_state != IDLE);

endmodule
